// File: rtl/bist_scan_sequencer_pkg.sv
// Shared BIST definitions: FSM state encoding and signature constants
// used by the sequencer, the MISR and the BIST top level.
package bist_pkg;

  localparam int SIG_W = 3;
  localparam logic [SIG_W-1:0] GOLDEN_SIG = 3'b101;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    FLUSH   = 3'd4,
    COMPARE = 3'd5,
    DONE    = 3'd6
  } bist_state_t;

endpackage

// File: rtl/bist_scan_sequencer_if.sv
// Control/status bundle between the BIST sequencer and its surroundings.
//
// Handshake: START is a level request, looked at only while the sequencer is
// idle or done. Once a session begins it runs to completion; bist_end then
// rises and stays high (with pass_fail valid) until START is seen low, at
// which point the sequencer returns to idle and bist_end drops.
interface bist_scan_sequencer_if #(
  parameter int SIG_W = bist_pkg::SIG_W
);
  logic             START;
  logic [SIG_W-1:0] misr_sig;
  logic             test_sel;
  logic             scan_en;
  logic             lfsr_load;
  logic             lfsr_en;
  logic             misr_clr;
  logic             misr_en;
  logic             running;
  logic             bist_end;
  logic             pass_fail;

  // Sequencer side
  modport master (
    input  START, misr_sig,
    output test_sel, scan_en, lfsr_load, lfsr_en, misr_clr, misr_en,
           running, bist_end, pass_fail
  );

  // Requester / observer side
  modport slave (
    output START, misr_sig,
    input  test_sel, scan_en, lfsr_load, lfsr_en, misr_clr, misr_en,
           running, bist_end, pass_fail
  );
endinterface

// File: rtl/bist_scan_sequencer_term_counter.sv
// Up-counter with synchronous clear and enable. It returns to zero on its own
// after reaching TERM-1, so it never wraps through its full range.
module bist_term_counter #(
  parameter int W    = 8,
  parameter int TERM = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  localparam logic [W-1:0] LAST = W'(TERM - 1);

  logic [W-1:0] cnt_d, cnt_q;

  assign cnt = cnt_q;
  assign tc  = (cnt_q == LAST);

  // Next count: clear wins, then advance or restart at the terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/bist_scan_sequencer.sv
// BIST session sequencer: drives scan enable, test mux select, LFSR and MISR
// control, then compares the final MISR signature against the golden value.
module bist_scan_sequencer
  import bist_pkg::*;
#(
  parameter int               CHAIN_LEN  = 4,
  parameter int               N_PATTERNS = 200,
  parameter int               PAT_CNT_W  = 8,
  parameter int               SIG_W      = bist_pkg::SIG_W,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = bist_pkg::GOLDEN_SIG
) (
  input  logic                             CLK,
  input  logic                             RST,
  bist_scan_sequencer_if.master            bus,
  output bist_state_t                      dbg_state,
  output logic [$clog2(CHAIN_LEN+1)-1:0]   dbg_bit_cnt
);
  localparam int BIT_CNT_W = $clog2(CHAIN_LEN + 1);

  bist_state_t          state_d, state_q;
  logic                 pass_fail_d, pass_fail_q;
  logic                 bit_clr, bit_en, bit_tc;
  logic                 pat_clr, pat_en, pat_tc;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [PAT_CNT_W-1:0] pat_cnt;

  // Bit counter paces both the per-pattern shift and the final flush
  bist_term_counter #(.W(BIT_CNT_W), .TERM(CHAIN_LEN)) u_bit_cnt (
    .clk (CLK),
    .rst (RST),
    .clr (bit_clr),
    .en  (bit_en),
    .cnt (bit_cnt),
    .tc  (bit_tc)
  );

  // Pattern counter advances once per capture
  bist_term_counter #(.W(PAT_CNT_W), .TERM(N_PATTERNS)) u_pat_cnt (
    .clk (CLK),
    .rst (RST),
    .clr (pat_clr),
    .en  (pat_en),
    .cnt (pat_cnt),
    .tc  (pat_tc)
  );

  assign dbg_state   = state_q;
  assign dbg_bit_cnt = bit_cnt;

  // Next state, counter controls and the pass/fail verdict
  always_comb begin
    state_d     = state_q;
    pass_fail_d = pass_fail_q;
    bit_clr     = 1'b0;
    bit_en      = 1'b0;
    pat_clr     = 1'b0;
    pat_en      = 1'b0;
    case (state_q)
      IDLE:    if (bus.START) state_d = INIT;
      INIT: begin
        bit_clr     = 1'b1;
        pat_clr     = 1'b1;
        pass_fail_d = 1'b0;
        state_d     = SHIFT;
      end
      SHIFT: begin
        bit_en = 1'b1;
        if (bit_tc) state_d = CAPTURE;
      end
      CAPTURE: begin
        pat_en  = 1'b1;
        state_d = pat_tc ? FLUSH : SHIFT;
      end
      FLUSH: begin
        bit_en = 1'b1;
        if (bit_tc) state_d = COMPARE;
      end
      COMPARE: begin
        pass_fail_d = (bus.misr_sig == GOLDEN_SIG);
        state_d     = DONE;
      end
      DONE:    if (!bus.START) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and verdict registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      pass_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pass_fail_q <= pass_fail_d;
    end
  end

  // Outputs decode from registers only; the first unload of a session is
  // skipped by the MISR because the chain still holds power-up content
  always_comb begin
    bus.test_sel  = 1'b0;
    bus.scan_en   = 1'b0;
    bus.lfsr_load = 1'b0;
    bus.lfsr_en   = 1'b0;
    bus.misr_clr  = 1'b0;
    bus.misr_en   = 1'b0;
    bus.running   = 1'b0;
    bus.bist_end  = 1'b0;
    bus.pass_fail = pass_fail_q;
    case (state_q)
      INIT: begin
        bus.lfsr_load = 1'b1;
        bus.misr_clr  = 1'b1;
        bus.test_sel  = 1'b1;
        bus.running   = 1'b1;
      end
      SHIFT: begin
        bus.scan_en  = 1'b1;
        bus.lfsr_en  = 1'b1;
        bus.test_sel = 1'b1;
        bus.running  = 1'b1;
        bus.misr_en  = (pat_cnt != '0);
      end
      CAPTURE: begin
        bus.lfsr_en  = 1'b1;
        bus.misr_en  = 1'b1;
        bus.test_sel = 1'b1;
        bus.running  = 1'b1;
      end
      FLUSH: begin
        bus.scan_en  = 1'b1;
        bus.misr_en  = 1'b1;
        bus.test_sel = 1'b1;
        bus.running  = 1'b1;
      end
      COMPARE: bus.running  = 1'b1;
      DONE:    bus.bist_end = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_bist_scan_sequencer.sv
// Bench for bist_scan_sequencer: a default-sized instance (A) and a small
// CHAIN_LEN=2 / N_PATTERNS=3 instance (B) share one clock. Drivers push the
// expected end cycle, verdict and running length per session; monitors pop
// on every bist_end rising edge.
module tb_bist_scan_sequencer;
  import bist_pkg::*;

  localparam int LAT_A = 1 + 200 * (4 + 1) + 4 + 1;  // 1006
  localparam int LAT_B = 1 + 3 * (2 + 1) + 2 + 1;    // 13

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bist_scan_sequencer_if #(.SIG_W(3)) if_a ();
  bist_scan_sequencer_if #(.SIG_W(3)) if_b ();
  bist_state_t st_a, st_b;
  logic [2:0]  bc_a;
  logic [1:0]  bc_b;

  bist_scan_sequencer dut_a (
    .CLK(clk), .RST(rst_a), .bus(if_a), .dbg_state(st_a), .dbg_bit_cnt(bc_a)
  );

  bist_scan_sequencer #(.CHAIN_LEN(2), .N_PATTERNS(3), .PAT_CNT_W(2)) dut_b (
    .CLK(clk), .RST(rst_b), .bus(if_b), .dbg_state(st_b), .dbg_bit_cnt(bc_b)
  );

  // Scoreboard: {pass, end_cycle[31:0], running_cycles[15:0]}
  logic [48:0] exp_qa[$];
  logic [48:0] exp_qb[$];
  int checks = 0;
  int errors = 0;
  int clr_cnt_b = 0;
  int load_cnt_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [48:0] pack_exp(input logic pass, input int end_cyc, input int run);
    return {pass, end_cyc[31:0], run[15:0]};
  endfunction

  function automatic logic [8:0] outs_a();
    return {if_a.test_sel, if_a.scan_en, if_a.lfsr_load, if_a.lfsr_en, if_a.misr_clr,
            if_a.misr_en, if_a.running, if_a.bist_end, if_a.pass_fail};
  endfunction

  function automatic logic [8:0] outs_b();
    return {if_b.test_sel, if_b.scan_en, if_b.lfsr_load, if_b.lfsr_en, if_b.misr_clr,
            if_b.misr_en, if_b.running, if_b.bist_end, if_b.pass_fail};
  endfunction

  // Monitor: counts running cycles and checks each completed session
  task automatic monitor(input bit is_b);
    int          run_cnt = 0;
    logic        be_prev = 1'b0;
    logic        be, rn, pf, rs;
    logic [48:0] e;
    string       tag;
    tag = is_b ? "b" : "a";
    forever begin
      @(negedge clk);
      be = is_b ? if_b.bist_end : if_a.bist_end;
      rn = is_b ? if_b.running  : if_a.running;
      pf = is_b ? if_b.pass_fail : if_a.pass_fail;
      rs = is_b ? rst_b : rst_a;
      if (rs) begin
        run_cnt = 0;
        be_prev = 1'b0;
      end else begin
        if (rn) run_cnt++;
        if (is_b && if_b.misr_clr)  clr_cnt_b++;
        if (is_b && if_b.lfsr_load) load_cnt_b++;
        if (be && !be_prev) begin
          if ((is_b ? exp_qb.size() : exp_qa.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_end: bist_end rose at cycle %0d with nothing expected", tag, cyc);
          end else begin
            e = is_b ? exp_qb.pop_front() : exp_qa.pop_front();
            check($sformatf("%s_end_cycle", tag), cyc, e[47:16]);
            check($sformatf("%s_pass_fail", tag), {31'd0, pf}, {31'd0, e[48]});
            check($sformatf("%s_running_len", tag), run_cnt, {16'd0, e[15:0]});
          end
          run_cnt = 0;
        end
        be_prev = be;
      end
    end
  endtask

  // Driver: request a session on A, optionally dropping START after one cycle
  task automatic start_a(input logic pass_exp, input bit pulse);
    @(negedge clk);
    if_a.START = 1'b1;
    exp_qa.push_back(pack_exp(pass_exp, cyc + 1 + LAT_A, LAT_A));
    if (pulse) begin
      @(negedge clk);
      if_a.START = 1'b0;
    end
  endtask

  task automatic start_b();
    @(negedge clk);
    if_b.START = 1'b1;
    exp_qb.push_back(pack_exp(1'b1, cyc + 1 + LAT_B, LAT_B));
    @(negedge clk);
    if_b.START = 1'b0;
  endtask

  task automatic wait_end(input bit is_b, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = is_b ? if_b.bist_end : if_a.bist_end;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no bist_end within %0d cycles", is_b ? "b" : "a", budget);
    end
  endtask

  // Main stimulus
  initial begin
    logic [12:0] scan_tbl, misr_tbl, lfsr_tbl, clr_tbl;
    scan_tbl = 13'b0110110110110;
    misr_tbl = 13'b0111111111000;
    lfsr_tbl = 13'b0001111111110;
    clr_tbl  = 13'b0000000000001;

    fork
      monitor(1'b0);
      monitor(1'b1);
    join_none

    if_a.START = 1'b0;
    if_b.START = 1'b0;
    if_a.misr_sig = 3'b101;
    if_b.misr_sig = 3'b101;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    check("a_reset_outs", {23'd0, outs_a()}, 32'd0);
    check("b_reset_outs", {23'd0, outs_b()}, 32'd0);
    check("a_reset_state", 32'(st_a), 32'(IDLE));

    // Small instance: per-cycle control pattern, then two more sessions
    @(negedge clk);
    if_b.START = 1'b1;
    exp_qb.push_back(pack_exp(1'b1, cyc + 1 + LAT_B, LAT_B));
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      if (j == 0) if_b.START = 1'b0;
      check($sformatf("b_scan_en_%0d", j),  {31'd0, if_b.scan_en},  {31'd0, scan_tbl[j]});
      check($sformatf("b_misr_en_%0d", j),  {31'd0, if_b.misr_en},  {31'd0, misr_tbl[j]});
      check($sformatf("b_lfsr_en_%0d", j),  {31'd0, if_b.lfsr_en},  {31'd0, lfsr_tbl[j]});
      check($sformatf("b_misr_clr_%0d", j), {31'd0, if_b.misr_clr}, {31'd0, clr_tbl[j]});
    end
    wait_end(1'b1, 5);
    start_b();
    wait_end(1'b1, 20);
    start_b();
    wait_end(1'b1, 20);
    @(negedge clk);
    check("b_misr_clr_pulses", clr_cnt_b, 3);
    check("b_lfsr_load_pulses", load_cnt_b, 3);

    // A: START held high through DONE
    start_a(1'b1, 1'b0);
    wait_end(1'b0, LAT_A + 100);
    repeat (10) @(negedge clk);
    check("a_done_hold_end", {31'd0, if_a.bist_end}, 32'd1);
    check("a_done_hold_running", {31'd0, if_a.running}, 32'd0);
    check("a_done_hold_state", 32'(st_a), 32'(DONE));
    if_a.START = 1'b0;
    @(negedge clk);
    check("a_idle_end_low", {31'd0, if_a.bist_end}, 32'd0);
    check("a_idle_state", 32'(st_a), 32'(IDLE));
    repeat (3) @(negedge clk);
    check("a_pass_held_idle", {31'd0, if_a.pass_fail}, 32'd1);

    // A: failing signature, single-cycle START pulse
    if_a.misr_sig = 3'b100;
    start_a(1'b0, 1'b1);
    @(negedge clk);
    check("a_pass_cleared_init", {31'd0, if_a.pass_fail}, 32'd0);
    wait_end(1'b0, LAT_A + 100);
    @(negedge clk);
    check("a_end_one_cycle", {31'd0, if_a.bist_end}, 32'd0);
    check("a_pulse_idle_state", 32'(st_a), 32'(IDLE));
    check("a_fail_held_idle", {31'd0, if_a.pass_fail}, 32'd0);

    // A: START toggling inside the session must not disturb timing
    if_a.misr_sig = 3'b101;
    start_a(1'b1, 1'b0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if_a.START = ~if_a.START;
    end
    if_a.START = 1'b0;
    wait_end(1'b0, LAT_A + 100);
    @(negedge clk);
    check("a_toggle_idle_state", 32'(st_a), 32'(IDLE));

    // A: reset mid-session, then a fresh full session
    @(negedge clk);
    if_a.START = 1'b1;
    @(negedge clk);
    if_a.START = 1'b0;
    repeat (499) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    check("a_midrst_outs", {23'd0, outs_a()}, 32'd0);
    check("a_midrst_state", 32'(st_a), 32'(IDLE));
    rst_a = 1'b0;
    start_a(1'b1, 1'b1);
    wait_end(1'b0, LAT_A + 100);
    @(negedge clk);
    check("a_post_rst_pass", {31'd0, if_a.pass_fail}, 32'd1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("a_idle_rst_pass", {31'd0, if_a.pass_fail}, 32'd0);

    repeat (3) @(negedge clk);
    check("a_queue_drained", exp_qa.size(), 0);
    check("b_queue_drained", exp_qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
